fe1_pc_redirect_t: RTL and testbench
====================================

Name: fe1_pc_redirect_t

Overview:
Fetch-stage PC generator and instruction-fetch controller; the consumer of the branch-resolution signal produced in the ME1 stage.
- Issues sequential fetch requests to instruction memory over a single-outstanding req/ack handshake.
- Registers the fetched instruction into the FE/DE boundary.
- On a taken branch (s_me1_pcsrc), redirects the PC to the resolved target and squashes younger stages.
- Discards any in-flight fetch belonging to the wrong path.

Parameters:
ADDR_W, 32, PC/address width in bits
RESET_PC, 32'h0000_0000, first fetch address after reset
INSTR_W, 32, instruction width in bits

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
ACT  input  1  pipeline activity enable; when 0, stage state holds and no redirect is taken
s_me1_pcsrc_D  input  1  branch taken, from ME1 stage (combinational, same cycle)
r_me1_target_Q  input  ADDR_W  resolved branch target, valid when s_me1_pcsrc_D=1
de_stall  input  1  decode cannot accept a new instruction
if_req  output  1  fetch request
if_addr  output  ADDR_W  fetch address; stable while if_req=1 and if_ack=0
if_ack  input  1  request complete; if_rdata valid this cycle
if_rdata  input  INSTR_W  fetched instruction
fe_valid  output  1  fe_instr/fe_pc hold a valid instruction
fe_pc  output  ADDR_W  PC of fe_instr
fe_instr  output  INSTR_W  fetched instruction to decode
flush_fe  output  1  squash FE/DE register (combinational)
flush_de  output  1  squash DE/EX register (combinational)
flush_ex  output  1  squash EX/ME register (combinational)

Behaviour:
- Reset (async, RST=1): state BOOT, pc_q=RESET_PC, if_req=0, if_addr=RESET_PC, fe_valid=0, fe_pc=RESET_PC, fe_instr=0, all flush=0.
- redirect = ACT & s_me1_pcsrc_D. flush_fe=flush_de=flush_ex=redirect, combinational, in the same cycle. Target bits [1:0] are forced to 0.
- States:
  - BOOT: if_req=0; next cycle → REQ with if_addr=pc_q.
  - REQ: if_req=1, if_addr=pc_q.
    - redirect & if_ack: discard if_rdata; pc_q←target; stay REQ (new address next cycle).
    - redirect & !if_ack: pc_q←target; → DROP.
    - if_ack & !redirect & (!fe_valid | !de_stall): fe_instr←if_rdata, fe_pc←pc_q, fe_valid←1, pc_q←pc_q+4; stay REQ (back-to-back, 1-cycle issue).
    - if_ack & fe_valid & de_stall: capture into a one-entry skid buffer (skid_pc, skid_instr), pc_q←pc_q+4; → HOLD.
  - HOLD: if_req=0.
    - redirect: drop skid, pc_q←target → REQ.
    - !de_stall: fe←skid; → REQ.
  - DROP: if_req=1 with the old address held (protocol stability); pc_q already holds target; the old address is kept in drop_addr. On if_ack: discard data → REQ. A second redirect in DROP updates pc_q only.
- fe output register: when !de_stall & !redirect and nothing new is captured, fe_valid←0. When de_stall & !redirect, fe_* hold. redirect always clears fe_valid at the next edge (redirect wins over stall and ack).
- ACT=0: no state change, no capture, if_req/if_addr hold; an outstanding ack is still honoured (data captured into skid/fe per rules).
- PC increment is modulo 2^ADDR_W (wraps 0xFFFF_FFFC → 0).
- Latency: ack in cycle N → fe_valid=1 in N+1; redirect in cycle N → if_req to target visible in N+1 (REQ) or after the old ack (DROP).

Optional Feature:
FE1_PERF_CNT_EN
- Defined: adds outputs perf_redirects (32) and perf_drops (32). Counters increment on redirect and on each discarded if_rdata respectively, saturate at all-ones, and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fe1_pkg: fetch FSM state enum (BOOT, REQ, HOLD, DROP), INSTR_BYTES=4, NOP constant, default RESET_PC.
- One sub-module, fe1_skid_buf_t: one-entry pc/instr skid buffer with valid, load and drain.
- FSM and PC logic stay in the top module.

Test Plan:
- Reset release, if_ack returned one cycle after every if_req → if_addr sequence 0x0, 0x4, 0x8, …; fe_valid=1 from the cycle after the first ack; fe_pc tracks the address.
- de_stall=1 for 3 cycles while ack arrives for 0x8 → fe holds 0x4; skid holds 0x8; if_req=0 in HOLD; on stall release fe_pc=0x8, then request 0xC.
- redirect with target 0x100 in the same cycle as the ack for 0x10 → flush_* =1 that cycle; 0x10 is never valid on fe; next if_addr=0x100.
- redirect to 0x200 while 0x14 is pending with no ack for 2 cycles → if_addr stays 0x14 until ack; data dropped; next if_addr=0x200; fe_valid=0 throughout.
- redirect with de_stall=1 and a full skid → redirect wins: fe_valid=0 next cycle, skid cleared, fetch resumes at the target.
- pc_q=0xFFFF_FFFC, then ack → next if_addr=0x0. Async RST asserted mid-DROP → outputs return to reset values immediately, with no clock edge.

Source files
------------

// File: rtl/fe1_pkg.sv
// Shared types and constants for the FE1 fetch stage (PC generator + fetch control).
package fe1_pkg;
    typedef enum logic [1:0] {
        BOOT,
        REQ,
        HOLD,
        DROP
    } fe1_state_e;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fe1_pc_redirect_t_if.sv
// Instruction-fetch bus: single-outstanding req/ack handshake to instruction memory.
interface fe1_pc_redirect_t_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_ack;
    logic [INSTR_W-1:0] if_rdata;

    modport master (output if_req, output if_addr, input if_ack, input if_rdata);
    modport slave  (input if_req, input if_addr, output if_ack, output if_rdata);
endinterface

// File: rtl/fe1_skid_buf_t.sv
// One-entry pc/instr skid buffer; load fills it, drain empties it (load has priority).
module fe1_skid_buf_t #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               drain,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fe1_pc_redirect_t.sv
// Fetch-stage PC generator / fetch controller with ME1 branch redirect and wrong-path drop.
// Optional saturating perf counters under `define FE1_PERF_CNT_EN.
module fe1_pc_redirect_t
    import fe1_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       INSTR_W  = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ACT,
    input  logic                 s_me1_pcsrc_D,
    input  logic [ADDR_W-1:0]    r_me1_target_Q,
    input  logic                 de_stall,
    fe1_pc_redirect_t_if.master  imem,
    output logic                 fe_valid,
    output logic [ADDR_W-1:0]    fe_pc,
    output logic [INSTR_W-1:0]   fe_instr,
    output logic                 flush_fe,
    output logic                 flush_de,
    output logic                 flush_ex
`ifdef FE1_PERF_CNT_EN
    ,
    output logic [31:0]          perf_redirects,
    output logic [31:0]          perf_drops
`endif
);
    fe1_state_e         state, state_n;
    logic [ADDR_W-1:0]  pc_q, pc_n, drop_addr, drop_addr_n;
    logic               redirect, fe_accept, fe_from_mem, fe_from_skid;
    logic               skid_load, skid_drain, skid_valid, drop_evt;
    logic [ADDR_W-1:0]  tgt, pc_inc, skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    assign redirect = ACT & s_me1_pcsrc_D;
    assign flush_fe = redirect;
    assign flush_de = redirect;
    assign flush_ex = redirect;
    assign tgt      = r_me1_target_Q & ~ADDR_W'(3);
    assign pc_inc   = pc_q + ADDR_W'(INSTR_BYTES);
    // A frozen pipeline (ACT=0) means decode is not consuming, so only an empty fe accepts.
    assign fe_accept = !fe_valid || (ACT && !de_stall);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= BOOT;
            pc_q      <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state     <= state_n;
            pc_q      <= pc_n;
            drop_addr <= drop_addr_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc_q;
        drop_addr_n  = drop_addr;
        fe_from_mem  = 1'b0;
        fe_from_skid = 1'b0;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        drop_evt     = 1'b0;
        case (state)
            BOOT: begin
                if (ACT) state_n = REQ;
                if (redirect) pc_n = tgt;
            end
            REQ: begin
                if (redirect) begin
                    pc_n = tgt;
                    if (imem.if_ack) begin
                        drop_evt = 1'b1;
                    end else begin
                        state_n     = DROP;
                        drop_addr_n = pc_q;
                    end
                end else if (imem.if_ack) begin
                    pc_n = pc_inc;
                    if (fe_accept) begin
                        fe_from_mem = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_n   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    skid_drain = 1'b1;
                    pc_n       = tgt;
                    state_n    = REQ;
                end else if (ACT && !de_stall && skid_valid) begin
                    skid_drain   = 1'b1;
                    fe_from_skid = 1'b1;
                    state_n      = REQ;
                end
            end
            DROP: begin
                // The old request stays on the bus until acked; pc_q already points at the target.
                if (redirect) pc_n = tgt;
                if (imem.if_ack) begin
                    drop_evt = 1'b1;
                    state_n  = REQ;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_comb begin
        imem.if_req  = (state == REQ) || (state == DROP);
        imem.if_addr = (state == DROP) ? drop_addr : pc_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fe_valid <= 1'b0;
            fe_pc    <= RESET_PC;
            fe_instr <= '0;
        end else if (redirect) begin
            fe_valid <= 1'b0;
        end else if (fe_from_mem) begin
            fe_valid <= 1'b1;
            fe_pc    <= pc_q;
            fe_instr <= imem.if_rdata;
        end else if (fe_from_skid) begin
            fe_valid <= 1'b1;
            fe_pc    <= skid_pc;
            fe_instr <= skid_instr;
        end else if (ACT && !de_stall) begin
            fe_valid <= 1'b0;
        end
    end

    fe1_skid_buf_t #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
        .clk        (CLK),
        .rst        (RST),
        .load       (skid_load),
        .drain      (skid_drain),
        .load_pc    (pc_q),
        .load_instr (imem.if_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

`ifdef FE1_PERF_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_redirects <= '0;
            perf_drops     <= '0;
        end else begin
            if (redirect && (perf_redirects != '1)) perf_redirects <= perf_redirects + 32'd1;
            if (drop_evt && (perf_drops != '1))     perf_drops     <= perf_drops + 32'd1;
        end
    end
`else
    logic unused_drop_evt;
    assign unused_drop_evt = drop_evt;
`endif
endmodule

// File: tb/tb_fe1_pc_redirect_t.sv
// Directed bench for fe1_pc_redirect_t: sequential fetch, stall/skid, redirects, wrap, async reset.
module tb_fe1_pc_redirect_t;
    logic        CLK = 1'b0;
    logic        RST, ACT, pcsrc, de_stall;
    logic [31:0] target;
    logic        fe_valid, flush_fe, flush_de, flush_ex;
    logic [31:0] fe_pc, fe_instr;
    int          checks = 0;
    int          failures = 0;

    fe1_pc_redirect_t_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

    fe1_pc_redirect_t #(.ADDR_W(32), .RESET_PC(32'h0), .INSTR_W(32)) dut (
        .CLK(CLK), .RST(RST), .ACT(ACT), .s_me1_pcsrc_D(pcsrc), .r_me1_target_Q(target),
        .de_stall(de_stall), .imem(imem), .fe_valid(fe_valid), .fe_pc(fe_pc),
        .fe_instr(fe_instr), .flush_fe(flush_fe), .flush_de(flush_de), .flush_ex(flush_ex)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {8'hC3, a[23:0]};
    endfunction

    assign imem.if_rdata = fdat(imem.if_addr);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; ACT = 1'b1; pcsrc = 1'b0; target = '0; de_stall = 1'b0; imem.if_ack = 1'b0;
        #3;
        checks++; if ({imem.if_req, imem.if_addr} !== {1'b0, 32'h0}) begin failures++; $display("FAIL reset_bus got=%b/%h exp=0/00000000", imem.if_req, imem.if_addr); end
        checks++; if ({fe_valid, fe_pc, fe_instr} !== {1'b0, 32'h0, 32'h0}) begin failures++; $display("FAIL reset_fe got=%b/%h/%h exp=0/0/0", fe_valid, fe_pc, fe_instr); end
        checks++; if ({flush_fe, flush_de, flush_ex} !== 3'b000) begin failures++; $display("FAIL reset_flush got=%b exp=000", {flush_fe, flush_de, flush_ex}); end
        tick(); tick();
        @(negedge CLK); RST = 1'b0; #1;
        checks++; if (imem.if_req !== 1'b0) begin failures++; $display("FAIL boot_req got=%b exp=0", imem.if_req); end
        tick();
        checks++; if ({imem.if_req, imem.if_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL boot_to_req got=%b/%h exp=1/00000000", imem.if_req, imem.if_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            a = 32'(i * 4);
            imem.if_ack = 1'b0; tick();
            checks++; if ({imem.if_req, imem.if_addr} !== {1'b1, a}) begin failures++; $display("FAIL seq_addr_stable got=%b/%h exp=1/%h", imem.if_req, imem.if_addr, a); end
            imem.if_ack = 1'b1; tick(); imem.if_ack = 1'b0;
            checks++; if ({fe_valid, fe_pc, fe_instr} !== {1'b1, a, fdat(a)}) begin failures++; $display("FAIL seq_fe got=%b/%h/%h exp=1/%h/%h", fe_valid, fe_pc, fe_instr, a, fdat(a)); end
            checks++; if (imem.if_addr !== a + 32'h4) begin failures++; $display("FAIL seq_next_addr got=%h exp=%h", imem.if_addr, a + 32'h4); end
        end
    endtask

    task automatic test_stall();
        de_stall = 1'b1; imem.if_ack = 1'b1; tick(); imem.if_ack = 1'b0;
        checks++; if ({fe_valid, fe_pc, imem.if_req} !== {1'b1, 32'h4, 1'b0}) begin failures++; $display("FAIL stall_hold got=%b/%h/%b exp=1/00000004/0", fe_valid, fe_pc, imem.if_req); end
        tick(); tick();
        checks++; if ({fe_valid, fe_pc, imem.if_req} !== {1'b1, 32'h4, 1'b0}) begin failures++; $display("FAIL stall_hold3 got=%b/%h/%b exp=1/00000004/0", fe_valid, fe_pc, imem.if_req); end
        de_stall = 1'b0; tick();
        checks++; if ({fe_valid, fe_pc, fe_instr} !== {1'b1, 32'h8, fdat(32'h8)}) begin failures++; $display("FAIL skid_drain got=%b/%h/%h exp=1/00000008/%h", fe_valid, fe_pc, fe_instr, fdat(32'h8)); end
        checks++; if ({imem.if_req, imem.if_addr} !== {1'b1, 32'hC}) begin failures++; $display("FAIL after_skid_addr got=%b/%h exp=1/0000000c", imem.if_req, imem.if_addr); end
    endtask

    task automatic test_back_to_back();
        imem.if_ack = 1'b1; tick();
        checks++; if ({fe_valid, fe_pc, imem.if_addr} !== {1'b1, 32'hC, 32'h10}) begin failures++; $display("FAIL b2b got=%b/%h/%h exp=1/0000000c/00000010", fe_valid, fe_pc, imem.if_addr); end
    endtask

    task automatic test_redirect_ack();
        imem.if_ack = 1'b1; pcsrc = 1'b1; target = 32'h103; #1;
        checks++; if ({flush_fe, flush_de, flush_ex} !== 3'b111) begin failures++; $display("FAIL redir_flush got=%b exp=111", {flush_fe, flush_de, flush_ex}); end
        tick(); pcsrc = 1'b0; imem.if_ack = 1'b0; #1;
        checks++; if ({flush_fe, fe_valid} !== 2'b00) begin failures++; $display("FAIL redir_after got=%b/%b exp=0/0", flush_fe, fe_valid); end
        checks++; if ({imem.if_req, imem.if_addr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL redir_target got=%b/%h exp=1/00000100", imem.if_req, imem.if_addr); end
    endtask

    task automatic test_drop();
        imem.if_ack = 1'b1; tick();
        checks++; if ({fe_valid, fe_pc, imem.if_addr} !== {1'b1, 32'h100, 32'h104}) begin failures++; $display("FAIL drop_pre got=%b/%h/%h exp=1/00000100/00000104", fe_valid, fe_pc, imem.if_addr); end
        imem.if_ack = 1'b0; pcsrc = 1'b1; target = 32'h200; tick(); pcsrc = 1'b0;
        checks++; if ({imem.if_req, imem.if_addr, fe_valid} !== {1'b1, 32'h104, 1'b0}) begin failures++; $display("FAIL drop_hold1 got=%b/%h/%b exp=1/00000104/0", imem.if_req, imem.if_addr, fe_valid); end
        pcsrc = 1'b1; target = 32'h300; tick(); pcsrc = 1'b0;
        checks++; if ({imem.if_req, imem.if_addr, fe_valid} !== {1'b1, 32'h104, 1'b0}) begin failures++; $display("FAIL drop_hold2 got=%b/%h/%b exp=1/00000104/0", imem.if_req, imem.if_addr, fe_valid); end
        imem.if_ack = 1'b1; tick(); imem.if_ack = 1'b0;
        checks++; if ({imem.if_req, imem.if_addr, fe_valid} !== {1'b1, 32'h300, 1'b0}) begin failures++; $display("FAIL drop_done got=%b/%h/%b exp=1/00000300/0", imem.if_req, imem.if_addr, fe_valid); end
    endtask

    task automatic test_redirect_over_stall();
        de_stall = 1'b1; imem.if_ack = 1'b1; tick();
        checks++; if ({fe_valid, fe_pc, imem.if_addr} !== {1'b1, 32'h300, 32'h304}) begin failures++; $display("FAIL rs_fill got=%b/%h/%h exp=1/00000300/00000304", fe_valid, fe_pc, imem.if_addr); end
        tick(); imem.if_ack = 1'b0;
        checks++; if ({imem.if_req, fe_pc} !== {1'b0, 32'h300}) begin failures++; $display("FAIL rs_hold got=%b/%h exp=0/00000300", imem.if_req, fe_pc); end
        pcsrc = 1'b1; target = 32'h400; tick(); pcsrc = 1'b0; de_stall = 1'b0;
        checks++; if ({fe_valid, imem.if_req, imem.if_addr} !== {1'b0, 1'b1, 32'h400}) begin failures++; $display("FAIL rs_redirect got=%b/%b/%h exp=0/1/00000400", fe_valid, imem.if_req, imem.if_addr); end
        tick();
        checks++; if ({fe_valid, imem.if_addr} !== {1'b0, 32'h400}) begin failures++; $display("FAIL rs_skid_cleared got=%b/%h exp=0/00000400", fe_valid, imem.if_addr); end
    endtask

    task automatic test_act_gate();
        ACT = 1'b0; pcsrc = 1'b1; target = 32'h500; #1;
        checks++; if (flush_fe !== 1'b0) begin failures++; $display("FAIL act_flush got=%b exp=0", flush_fe); end
        tick(); ACT = 1'b1; pcsrc = 1'b0;
        checks++; if (imem.if_addr !== 32'h400) begin failures++; $display("FAIL act_no_redirect got=%h exp=00000400", imem.if_addr); end
    endtask

    task automatic test_wrap();
        pcsrc = 1'b1; target = 32'hFFFF_FFFC; imem.if_ack = 1'b1; tick(); pcsrc = 1'b0;
        checks++; if ({imem.if_addr, fe_valid} !== {32'hFFFF_FFFC, 1'b0}) begin failures++; $display("FAIL wrap_pre got=%h/%b exp=fffffffc/0", imem.if_addr, fe_valid); end
        tick(); imem.if_ack = 1'b0;
        checks++; if ({fe_valid, fe_pc, imem.if_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin failures++; $display("FAIL wrap got=%b/%h/%h exp=1/fffffffc/00000000", fe_valid, fe_pc, imem.if_addr); end
    endtask

    task automatic test_async_reset_in_drop();
        imem.if_ack = 1'b1; tick();
        imem.if_ack = 1'b0; pcsrc = 1'b1; target = 32'h600; tick(); pcsrc = 1'b0;
        checks++; if ({imem.if_req, imem.if_addr} !== {1'b1, 32'h4}) begin failures++; $display("FAIL pre_rst_drop got=%b/%h exp=1/00000004", imem.if_req, imem.if_addr); end
        #2 RST = 1'b1; #1;
        checks++; if ({imem.if_req, imem.if_addr} !== {1'b0, 32'h0}) begin failures++; $display("FAIL async_rst_bus got=%b/%h exp=0/00000000", imem.if_req, imem.if_addr); end
        checks++; if ({fe_valid, fe_pc, fe_instr} !== {1'b0, 32'h0, 32'h0}) begin failures++; $display("FAIL async_rst_fe got=%b/%h/%h exp=0/0/0", fe_valid, fe_pc, fe_instr); end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_back_to_back();
        test_redirect_ack();
        test_drop();
        test_redirect_over_stall();
        test_act_gate();
        test_wrap();
        test_async_reset_in_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
